// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 UART receiver with 16x oversampling.
//
// Parameters
//   CLK_FREQ     clk_i frequency in Hz
//   BAUD_RATE    serial bit rate in bit/s
//
// Ports
//   clk_i         single clock, all logic on its rising edge
//   rst_i         asynchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   data_o        last correctly framed byte, held between frames
//   data_valid_o  one-clock pulse when data_o is updated
//   frame_err_o   one-clock pulse when the stop bit samples low
//   busy_o        high whenever a frame is being received
module uart_rx_core #(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  // Clocks per 1/16 bit, rounded to nearest, never below 1.
  function automatic int calc_div(input longint f, input longint b);
    longint d;
    d = (f + 8 * b) / (16 * b);
    if (d < 1) d = 1;
    return int'(d);
  endfunction

  localparam int DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD_RATE));
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_p0;
  logic             rx_p1;
  logic             rx_p2;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;

  assign tick   = (div_cnt == DIV_LAST);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      rx_p0        <= 1'b1;
      rx_p1        <= 1'b1;
      rx_p2        <= 1'b1;
      div_cnt      <= '0;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchronizer; p2: previous synchronized sample
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;

      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;

      // Held at zero while idle so every frame starts with a fresh phase.
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          // Falling edge only: a line stuck low never starts a frame.
          if (rx_p2 && !rx_p1) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_p1 ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shreg <= {rx_p1, shreg[7:1]};
              if (bit_idx == 3'd7) begin
                bit_idx <= '0;
                state   <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            if (tick_cnt == 4'd15) begin
              state <= IDLE;
              if (rx_p1) begin
                data_o       <= shreg;
                data_valid_o <= 1'b1;
              end else begin
                frame_err_o  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- scoreboard bench for uart_rx_core.
// dut_a runs at 16 clocks per bit; dut_b uses the default parameters and
// receives one frame at 9600 baud stretched by 2%.
module tb_uart_rx_core;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       dv_a, fe_a, busy_a;
  logic       dv_b, fe_b, busy_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         lat;
    longint     t_fall;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_e;
  logic [7:0] last_good = 8'h00;
  int         vb_count = 0;

  uart_rx_core #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx_a),
    .data_o(data_a), .data_valid_o(dv_a), .frame_err_o(fe_a), .busy_o(busy_a)
  );

  uart_rx_core dut_b (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx_b),
    .data_o(data_b), .data_valid_o(dv_b), .frame_err_o(fe_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome of a frame follows from the stop bit alone: a good stop
  // publishes the byte, a bad one flags an error and leaves data_o alone.
  task automatic send_a(input logic [7:0] b, input bit stop, input bit lat, input bit glitch);
    ev_t e;
    e.err    = !stop;
    e.data   = stop ? b : last_good;
    e.lat    = lat;
    e.t_fall = longint'($time);
    if (stop) last_good = b;
    q.push_back(e);
    rx_a = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      if (glitch) begin
        rx_a = ~b[i];
        wait_clks(2);
        rx_a = b[i];
        wait_clks(14);
      end else begin
        rx_a = b[i];
        wait_clks(16);
      end
    end
    rx_a = stop;
    wait_clks(16);
  endtask

  // Scoreboard monitor for dut_a
  always @(negedge clk) begin
    if (rst_n && (dv_a || fe_a)) begin
      chk("a_valid_err_exclusive", longint'(dv_a & fe_a), 0);
      chk("a_event_expected", longint'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("a_event_is_err", longint'(fe_a), longint'(mon_e.err));
        chk("a_data_o", longint'(data_a), longint'(mon_e.data));
        if (mon_e.lat)
          chk_range("a_latency_clks", (longint'($time) - mon_e.t_fall) / 10, 149, 155);
      end
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin
    if (rst_n && (dv_b || fe_b)) begin
      chk("b_no_frame_err", longint'(fe_b), 0);
      if (dv_b) begin
        vb_count++;
        chk("b_data_o", longint'(data_b), 8'h5A);
      end
    end
  end

  initial begin
    int  gap;
    bit  prev_err;
    bit  st;
    logic [7:0] rb;

    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    wait_clks(3);
    chk("rst_data_o", longint'(data_a), 0);
    chk("rst_valid", longint'(dv_a), 0);
    chk("rst_frame_err", longint'(fe_a), 0);
    chk("rst_busy", longint'(busy_a), 0);
    rst_n = 1'b1;
    wait_clks(5);
    chk("idle_busy", longint'(busy_a), 0);

    // Single frame with latency check
    send_a(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_clks(10);

    // Back-to-back, zero idle
    send_a(8'h00, 1'b1, 1'b0, 1'b0);
    send_a(8'hFF, 1'b1, 1'b0, 1'b0);
    wait_clks(20);

    // Framing error, line held low, then recovery
    send_a(8'h3C, 1'b0, 1'b0, 1'b0);
    rx_a = 1'b0;
    wait_clks(40);
    rx_a = 1'b1;
    wait_clks(32);
    send_a(8'h81, 1'b1, 1'b0, 1'b0);
    wait_clks(20);

    // Short low glitch from idle
    rx_a = 1'b0;
    wait_clks(5);
    chk("glitch_busy_high", longint'(busy_a), 1);
    rx_a = 1'b1;
    wait_clks(20);
    chk("glitch_busy_low", longint'(busy_a), 0);

    // Reset during bit 4 of 0x55 (bit 4 is 1, so the line is high)
    rx_a = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = (8'h55 >> i) & 8'h01;
      wait_clks(16);
    end
    rx_a = 1'b1;
    wait_clks(8);
    chk("pre_reset_busy", longint'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_o", longint'(data_a), 0);
    chk("async_rst_busy", longint'(busy_a), 0);
    chk("async_rst_valid", longint'(dv_a | fe_a), 0);
    last_good = 8'h00;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(40);
    chk("post_reset_idle", longint'(busy_a), 0);
    send_a(8'h99, 1'b1, 1'b0, 1'b0);
    wait_clks(20);
    chk("after_reset_data_o", longint'(data_a), 8'h99);

    // Randomized frames, including mid-bit glitches away from the sample point
    prev_err = 1'b0;
    for (int n = 0; n < 30; n++) begin
      gap = prev_err ? int'($urandom_range(16, 48)) : int'($urandom_range(0, 40));
      rx_a = 1'b1;
      wait_clks(gap);
      rb = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_a(rb, st, 1'b0, 1'($urandom_range(0, 1)));
      prev_err = !st;
    end
    rx_a = 1'b1;

    for (int i = 0; i < 400 && q.size() != 0; i++) wait_clks(1);
    chk("a_queue_drained", longint'(q.size()), 0);

    // Default parameters, 0x5A at 9600 baud with 2% slow bit period
    @(negedge clk);
    rx_b = 1'b0;
    #10625;
    for (int i = 0; i < 8; i++) begin
      rx_b = (8'h5A >> i) & 8'h01;
      #10625;
    end
    rx_b = 1'b1;
    #10625;
    for (int i = 0; i < 3000 && vb_count == 0; i++) wait_clks(1);
    wait_clks(10);
    chk("b_valid_count", longint'(vb_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
